fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
//
// PURPOSE
// - Parametrised forwarding and load-use hazard unit for the pipelined CPU.
// - Keeps its own shift register of in-flight writers: the instructions now in EX, MEM, WB, ...
// - Compares the ID-stage source registers against these writers and produces:
//   - registered per-source forward selects, valid when the instruction reaches EX;
//   - a combinational load-use stall;
//   - a saturating stall counter.
// - Supersedes the fixed 2-source, 2-stage combinational forwarder.
//
// PARAMETERS
// REG_BITS   5   register index width
// NUM_SRC    2   source operands per instruction (Rn=0, Rm=1, ...)
// FWD_DEPTH  2   tracked writer stages (1 = EX->MEM result, 2 = MEM->WB result, ...)
// ZERO_REG   31  hardwired-zero register (XZR); never forwarded, never stalls
// CNT_W      16  stall counter width
// SEL_W = $clog2(FWD_DEPTH+1) (derived, not overridable)
//
// PORTS
// clk         in   1                 clock; all state updates on posedge
// reset       in   1                 synchronous, active-high
// id_valid    in   1                 ID holds a real instruction
// id_src      in   NUM_SRC*REG_BITS  source regs; src i = bits [i*REG_BITS +: REG_BITS]
// id_rd       in   REG_BITS          destination reg of ID instruction
// id_regwrite in   1                 ID instruction writes id_rd
// id_memread  in   1                 ID instruction is a load
// flush       in   1                 kill ID instruction (taken branch)
// stall       out  1                 hold PC and IF/ID; combinational
// ex_valid    out  1                 EX holds the instruction issued last cycle
// ex_fwd_sel  out  NUM_SRC*SEL_W     per-source select in EX; 0 = regfile, k = stage k
// stall_cnt   out  CNT_W             saturating count of stall cycles
//
// BEHAVIOUR
// - State: entries e[1..FWD_DEPTH], each {valid, rd, wr, load}.
//   - e[1] is the instruction currently in EX; e[k] is k-1 stages older.
// - match(s,k) = (s != ZERO_REG) & e[k].valid & e[k].wr & (e[k].rd == s).
// - hazard = id_valid & ~flush & OR over i of (match(src_i,1) & e[1].load).
// - stall = hazard & ~reset. Flush beats stall: a flushed instruction never stalls.
// - issue = id_valid & ~flush & ~stall.
// - sel_i = smallest k in 1..FWD_DEPTH with match(src_i,k), else 0.
//   - The youngest writer wins.
// - Each posedge, with reset low:
//   - e[k] <= e[k-1] for k >= 2. The tracked stages always advance; they never freeze.
//   - e[1] <= issue ? {1, id_rd, id_regwrite, id_memread} : bubble (all fields 0).
//   - ex_valid <= issue.
//   - ex_fwd_sel[i] <= issue ? sel_i : 0.
//   - stall_cnt <= stall_cnt + stall, holding at all-ones.
// - Latency: selects are registered. They apply 1 cycle after ID, while the instruction is in EX.
//   - By then e[1] has moved to MEM and e[2] to WB, so k names the stage the result is fetched from.
// - Load-use: a load in e[1] that matches a source gives stall=1 for exactly 1 cycle and a bubble in e[1].
//   - Next cycle the load is in e[2], the instruction issues, and sel = 2.
// - A load in e[k>=2] forwards normally; no stall.
// - Multiple sources may select different stages independently in the same cycle.
// - A write to ZERO_REG is tracked but never matches.
// - Reset high at any time:
//   - next edge: all entries invalid, ex_valid=0, ex_fwd_sel=0, stall_cnt=0;
//   - during reset: stall=0.
//   - An in-flight load stall is dropped.
//
// TESTING
// (defaults; X1 = reg 1)
// - ALU chain: issue ADD X1; next cycle ADD X2,X1,X1 ->
//   - stall=0;
//   - cycle after: ex_fwd_sel = {2'd1,2'd1}.
// - Distance 2: ADD X1, then an unrelated instruction, then SUB X3,X1,X4 ->
//   - Rn sel=2, Rm sel=0.
// - Priority: ADD X1, then ORR X1, then AND X5,X1,X1 ->
//   - both sel=1 (youngest), not 2.
// - Load-use: LDUR X1, then ADD X2,X1,X6 ->
//   - stall=1 for 1 cycle; bubble issued;
//   - ex_valid=0 then 1; ADD gets Rn sel=2; stall_cnt=1.
// - XZR, flush and regwrite:
//   - LDUR X31, then ADD X2,X31,X31 -> stall=0, sel=0.
//   - flush=1 during a load-use condition -> stall=0, ex_valid=0 next cycle.
//   - regwrite=0 writer -> sel=0.
// - Reset and saturation:
//   - assert reset mid-stall -> stall=0 immediately; all outputs 0 after the edge.
//   - CNT_W=2: 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Bus between the ID stage and the forwarding/hazard unit: ID-stage operand
// info in, stall and EX-stage forward selects out.
interface fwd_hazard_unit_if #(
    parameter int REG_BITS  = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int CNT_W     = 16
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                        id_valid;
    logic [NUM_SRC*REG_BITS-1:0] id_src;
    logic [REG_BITS-1:0]         id_rd;
    logic                        id_regwrite;
    logic                        id_memread;
    logic                        flush;
    logic                        stall;
    logic                        ex_valid;
    logic [NUM_SRC*SEL_W-1:0]    ex_fwd_sel;
    logic [CNT_W-1:0]            stall_cnt;

    modport master (
        output id_valid, id_src, id_rd, id_regwrite, id_memread, flush,
        input  stall, ex_valid, ex_fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_rd, id_regwrite, id_memread, flush,
        output stall, ex_valid, ex_fwd_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard unit. Tracks in-flight writers in a
// shift register and picks, per source operand, the youngest matching writer.

// Per-source matcher: youngest writer stage that targets src, plus whether
// the EX-stage writer (stage 1) matches, which feeds the load-use check.
module fwd_src_sel #(
    parameter int REG_BITS  = 5,
    parameter int FWD_DEPTH = 2,
    parameter int ZERO_REG  = 31,
    parameter int SEL_W     = 2
) (
    input  logic [REG_BITS-1:0]                src,
    input  logic [FWD_DEPTH:1]                 wr_live,
    input  logic [FWD_DEPTH:1][REG_BITS-1:0]   wr_rd,
    output logic [SEL_W-1:0]                   sel,
    output logic                               hit1
);
    logic nz;

    assign nz = (src != REG_BITS'(ZERO_REG));

    // Scan oldest to youngest so the youngest match is the last assignment
    always_comb begin
        sel = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (nz && wr_live[k] && (wr_rd[k] == src))
                sel = SEL_W'(k);
        end
        hit1 = nz & wr_live[1] & (wr_rd[1] == src);
    end
endmodule

module fwd_hazard_unit #(
    parameter int REG_BITS  = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int ZERO_REG  = 31,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    fwd_hazard_unit_if.slave bus
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    typedef struct packed {
        logic [REG_BITS-1:0] rd;
        logic                wr;
    } wr_ent_t;

    // Stage k = instruction k-1 stages older than the one now in EX
    logic    [FWD_DEPTH:1]      vld_pipe;
    wr_ent_t [FWD_DEPTH:1]      ent;
    // Only the EX-stage load matters: older loads already have their data
    logic                       ld_ex;

    logic [FWD_DEPTH:1]                 wr_live;
    logic [FWD_DEPTH:1][REG_BITS-1:0]   wr_rd;
    logic [NUM_SRC-1:0][SEL_W-1:0]      sel;
    logic [NUM_SRC-1:0]                 hit1;

    logic                       id_live;
    logic                       stall;
    logic                       issue;
    logic                       ex_valid_q;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel_q;
    logic [CNT_W-1:0]           cnt_q;

    // Flatten tracked writers into match inputs; a non-writing entry never matches
    always_comb begin
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            wr_live[k] = vld_pipe[k] & ent[k].wr;
            wr_rd[k]   = ent[k].rd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_src_sel #(
                .REG_BITS  (REG_BITS),
                .FWD_DEPTH (FWD_DEPTH),
                .ZERO_REG  (ZERO_REG),
                .SEL_W     (SEL_W)
            ) u_sel (
                .src     (bus.id_src[gi*REG_BITS +: REG_BITS]),
                .wr_live (wr_live),
                .wr_rd   (wr_rd),
                .sel     (sel[gi]),
                .hit1    (hit1[gi])
            );
        end
    endgenerate

    // A flushed instruction never stalls; reset suppresses any pending stall
    assign id_live = bus.id_valid & ~bus.flush;
    assign stall   = id_live & ld_ex & (|hit1) & ~reset;
    assign issue   = id_live & ~stall;

    assign bus.stall      = stall;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_fwd_sel = fwd_sel_q;
    assign bus.stall_cnt  = cnt_q;

    // Advance writer pipe every cycle; EX slot gets the issued instruction or a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe   <= '0;
            ent        <= '0;
            ld_ex      <= 1'b0;
            ex_valid_q <= 1'b0;
            fwd_sel_q  <= '0;
            cnt_q      <= '0;
        end else begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                vld_pipe[k] <= vld_pipe[k-1];
                ent[k]      <= ent[k-1];
            end
            vld_pipe[1] <= issue;
            if (issue) begin
                ent[1].rd <= bus.id_rd;
                ent[1].wr <= bus.id_regwrite;
                ld_ex     <= bus.id_memread;
                fwd_sel_q <= sel;
            end else begin
                ent[1]    <= '0;
                ld_ex     <= 1'b0;
                fwd_sel_q <= '0;
            end
            ex_valid_q <= issue;
            if (stall && !(&cnt_q))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default instance plus a CNT_W=2
// instance sharing the same inputs for the counter saturation case.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.CNT_W(16)) ba ();
    fwd_hazard_unit_if #(.CNT_W(2))  bb ();

    assign bb.id_valid    = ba.id_valid;
    assign bb.id_src      = ba.id_src;
    assign bb.id_rd       = ba.id_rd;
    assign bb.id_regwrite = ba.id_regwrite;
    assign bb.id_memread  = ba.id_memread;
    assign bb.flush       = ba.flush;

    fwd_hazard_unit #(.CNT_W(16)) u_dut (.clk(clk), .reset(reset), .bus(ba));
    fwd_hazard_unit #(.CNT_W(2))  u_sat (.clk(clk), .reset(reset), .bus(bb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present an instruction in ID: Rn, Rm, Rd, regwrite, memread
    task automatic id(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                      input logic wr, input logic ld);
        ba.id_valid    = 1'b1;
        ba.id_src      = {rm, rn};
        ba.id_rd       = rd;
        ba.id_regwrite = wr;
        ba.id_memread  = ld;
        ba.flush       = 1'b0;
    endtask

    task automatic idle();
        ba.id_valid    = 1'b0;
        ba.id_src      = '0;
        ba.id_rd       = '0;
        ba.id_regwrite = 1'b0;
        ba.id_memread  = 1'b0;
        ba.flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        id(5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
        #1;
        chk("rst_stall", {31'd0, ba.stall}, 32'd0);
        tick();
        tick();
        chk("rst_exv", {31'd0, ba.ex_valid}, 32'd0);
        chk("rst_sel", {28'd0, ba.ex_fwd_sel}, 32'd0);
        chk("rst_cnt", {16'd0, ba.stall_cnt}, 32'd0);
        reset = 1'b0;
        drain();

        // ALU chain: ADD X1; ADD X2,X1,X1
        id(5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
        tick();
        id(5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
        #1 chk("chain_stall", {31'd0, ba.stall}, 32'd0);
        tick();
        chk("chain_exv", {31'd0, ba.ex_valid}, 32'd1);
        chk("chain_sel", {28'd0, ba.ex_fwd_sel}, 32'h5);
        drain();

        // Distance 2: ADD X1; ADD X7,X8,X9; SUB X3,X1,X4
        id(5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
        tick();
        id(5'd8, 5'd9, 5'd7, 1'b1, 1'b0);
        tick();
        id(5'd1, 5'd4, 5'd3, 1'b1, 1'b0);
        tick();
        chk("dist2_sel", {28'd0, ba.ex_fwd_sel}, 32'h2);
        drain();

        // Priority: ADD X1; ORR X1; AND X5,X1,X1
        id(5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
        tick();
        id(5'd5, 5'd6, 5'd1, 1'b1, 1'b0);
        tick();
        id(5'd1, 5'd1, 5'd5, 1'b1, 1'b0);
        tick();
        chk("prio_sel", {28'd0, ba.ex_fwd_sel}, 32'h5);
        drain();

        // Load-use: LDUR X1,[X10]; ADD X2,X1,X6
        id(5'd10, 5'd0, 5'd1, 1'b1, 1'b1);
        tick();
        chk("ldu_ld_exv", {31'd0, ba.ex_valid}, 32'd1);
        id(5'd1, 5'd6, 5'd2, 1'b1, 1'b0);
        #1 chk("ldu_stall", {31'd0, ba.stall}, 32'd1);
        tick();
        chk("ldu_bubble", {31'd0, ba.ex_valid}, 32'd0);
        chk("ldu_stall2", {31'd0, ba.stall}, 32'd0);
        tick();
        chk("ldu_exv", {31'd0, ba.ex_valid}, 32'd1);
        chk("ldu_sel", {28'd0, ba.ex_fwd_sel}, 32'h2);
        chk("ldu_cnt", {16'd0, ba.stall_cnt}, 32'd1);
        drain();

        // XZR load never stalls or forwards
        id(5'd10, 5'd0, 5'd31, 1'b1, 1'b1);
        tick();
        id(5'd31, 5'd31, 5'd2, 1'b1, 1'b0);
        #1 chk("xzr_stall", {31'd0, ba.stall}, 32'd0);
        tick();
        chk("xzr_sel", {28'd0, ba.ex_fwd_sel}, 32'h0);
        chk("xzr_exv", {31'd0, ba.ex_valid}, 32'd1);
        drain();

        // Flush during load-use
        id(5'd10, 5'd0, 5'd1, 1'b1, 1'b1);
        tick();
        id(5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
        ba.flush = 1'b1;
        #1 chk("flush_stall", {31'd0, ba.stall}, 32'd0);
        tick();
        chk("flush_exv", {31'd0, ba.ex_valid}, 32'd0);
        drain();

        // Non-writing instruction targeting X1
        id(5'd3, 5'd1, 5'd1, 1'b0, 1'b0);
        tick();
        id(5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
        tick();
        chk("nowr_sel", {28'd0, ba.ex_fwd_sel}, 32'h0);
        chk("nowr_exv", {31'd0, ba.ex_valid}, 32'd1);
        chk("nowr_cnt", {16'd0, ba.stall_cnt}, 32'd1);
        drain();

        // Reset mid-stall
        id(5'd10, 5'd0, 5'd1, 1'b1, 1'b1);
        tick();
        id(5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
        #1 chk("rms_stall", {31'd0, ba.stall}, 32'd1);
        reset = 1'b1;
        #1 chk("rms_stall_rst", {31'd0, ba.stall}, 32'd0);
        tick();
        chk("rms_exv", {31'd0, ba.ex_valid}, 32'd0);
        chk("rms_sel", {28'd0, ba.ex_fwd_sel}, 32'h0);
        chk("rms_cnt", {16'd0, ba.stall_cnt}, 32'd0);
        reset = 1'b0;
        drain();

        // Saturation: LDUR X1,[X1] held stalls every other cycle
        id(5'd1, 5'd0, 5'd1, 1'b1, 1'b1);
        repeat (4) tick();
        chk("sat_cnt2", {30'd0, bb.stall_cnt}, 32'd2);
        repeat (6) tick();
        chk("sat_cnt_full", {16'd0, ba.stall_cnt}, 32'd5);
        chk("sat_cnt_w2", {30'd0, bb.stall_cnt}, 32'd3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
